// File: rtl/aes_job_sequencer.sv
// Purpose : streams one AES job: loads NWORDS_IN words into accelerator memory,
//           issues START_CMD, waits for completion (with timeout), then reads
//           NWORDS_OUT result words back out on a valid/ready stream.
// Latency : memory write 1 cycle after input handshake; first result RD_LAT+2
//           cycles after aes_complete_in is sampled high.
// Backpressure: in_ready only in IDLE/LOAD; out stream holds data/last stable
//           until out_ready, with no read-address advance while stalled.
// Ports   : in_* input job stream, out_* result stream (out_last on final word),
//           aes_* accelerator ctrl/memory ports, busy_out/error_out status.
module aes_job_sequencer #(
  parameter int         NWORDS_IN  = 6,
  parameter int         NWORDS_OUT = 6,
  parameter int         IN_BASE    = 0,
  parameter int         OUT_BASE   = 257,
  parameter logic [2:0] START_CMD  = 3'b001,
  parameter int         RD_LAT     = 2,
  parameter int         TIMEOUT    = 65535
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [2:0]  aes_ctrl_out,
  output logic [31:0] aes_data_out,
  output logic [3:0]  aes_mem_we_out,
  output logic [9:0]  aes_mem_wr_addr_out,
  output logic [9:0]  aes_mem_rd_addr_out,
  input  logic [31:0] aes_data_in,
  input  logic        aes_complete_in,
  output logic        busy_out,
  output logic        error_out
);

  localparam int            CW         = $clog2(64) + 1;
  localparam logic [CW-1:0] LAST_IN    = CW'(NWORDS_IN - 1);
  localparam logic [CW-1:0] LAST_OUT   = CW'(NWORDS_OUT - 1);
  localparam logic [CW-1:0] LAT_INIT   = CW'(RD_LAT);
  localparam logic [15:0]   TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [9:0]    IN_BASE_A  = 10'(IN_BASE);
  localparam logic [9:0]    OUT_BASE_A = 10'(OUT_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RD_ADDR,
    S_RD_WAIT,
    S_EMIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;        // input words accepted so far
  logic [CW-1:0] rcnt_q, rcnt_d;        // result index j
  logic [CW-1:0] lat_q, lat_d;          // read latency countdown
  logic [15:0]   to_q, to_d;            // WAIT cycle counter
  logic          err_q, err_d;
  logic [3:0]    we_q, we_d;
  logic [9:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [9:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          complete_q;            // completion is acted on one cycle after it is seen

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      lat_q      <= '0;
      to_q       <= '0;
      err_q      <= 1'b0;
      we_q       <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= OUT_BASE_A;
      out_data_q <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      lat_q      <= lat_d;
      to_q       <= to_d;
      err_q      <= err_d;
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      out_data_q <= out_data_d;
      complete_q <= aes_complete_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    lat_d      = lat_q;
    to_d       = to_q;
    err_d      = err_q;
    we_d       = 4'h0;               // write strobe is a single-cycle pulse
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          we_d      = 4'hf;
          wr_addr_d = IN_BASE_A;
          wr_data_d = in_data;
          wcnt_d    = CW'(1);
          rcnt_d    = '0;
          err_d     = 1'b0;
          state_d   = (NWORDS_IN == 1) ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          we_d      = 4'hf;
          wr_addr_d = IN_BASE_A + 10'(wcnt_q);
          wr_data_d = in_data;
          wcnt_d    = wcnt_q + CW'(1);
          if (wcnt_q == LAST_IN) state_d = S_START;
        end
      end
      S_START: begin
        to_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion is checked first so it wins a same-cycle race with expiry.
        if (complete_q) begin
          state_d = S_RD_ADDR;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_RD_ADDR: begin
        rd_addr_d = OUT_BASE_A + 10'(rcnt_q);
        lat_d     = LAT_INIT;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        lat_d = lat_q - CW'(1);
        if (lat_q == CW'(1)) begin
          out_data_d = aes_data_in;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (rcnt_q == LAST_OUT) begin
            state_d = S_IDLE;
          end else begin
            rcnt_d  = rcnt_q + CW'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready            = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign out_valid           = (state_q == S_EMIT);
  assign out_last            = (state_q == S_EMIT) && (rcnt_q == LAST_OUT);
  assign out_data            = out_data_q;
  assign aes_ctrl_out        = ((state_q == S_START) || (state_q == S_WAIT)) ? START_CMD : 3'b000;
  assign aes_data_out        = wr_data_q;
  assign aes_mem_we_out      = we_q;
  assign aes_mem_wr_addr_out = wr_addr_q;
  assign aes_mem_rd_addr_out = rd_addr_q;
  assign busy_out            = (state_q != S_IDLE);
  assign error_out           = err_q;

endmodule
